// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter and sequencer sharing one 16x8 memory between two
// requesters. One transaction (read or write) is in flight at a time; the
// winner receives a one-cycle grant, and reads return data with a
// per-requester valid pulse. All outputs are registered.
module mem_rr_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  // requester 0
  input  logic              req0,
  input  logic              wr0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  // requester 1
  input  logic              req1,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  // memory side
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_w_add,
  output logic [ADDR_W-1:0] mem_r_add,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  // status
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RD_WAIT = 2'd2,
    RD_DONE = 2'd3
  } state_t;

  // Final count value of the read-wait counter (RD_LAT is 1..3).
  localparam logic [1:0] LAST_CNT = 2'(RD_LAT - 1);

  state_t      state;
  logic        prio;       // requester that wins when both request
  logic        win;        // requester owning the current transaction
  logic        lat_wr;     // direction of the current transaction
  logic [1:0]  wait_cnt;   // cycles spent in RD_WAIT

  logic              any_req;
  logic              pick;
  logic              sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // Choose the winner from the live requests and mux its transaction fields.
  always_comb begin
    any_req   = req0 | req1;
    pick      = (req0 & req1) ? prio : req1;
    sel_wr    = pick ? wr1    : wr0;
    sel_addr  = pick ? addr1  : addr0;
    sel_wdata = pick ? wdata1 : wdata0;
  end

  // Transaction sequencer: state, arbitration pointer and all registered outputs.
  // The winner's address/data are latched straight into the memory-side
  // registers, which therefore double as the transaction latch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      prio        <= 1'b0;
      win         <= 1'b0;
      lat_wr      <= 1'b0;
      wait_cnt    <= 2'd0;
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      rvalid0     <= 1'b0;
      rvalid1     <= 1'b0;
      rdata0      <= '0;
      rdata1      <= '0;
      mem_we      <= 1'b0;
      mem_re      <= 1'b0;
      mem_w_add   <= '0;
      mem_r_add   <= '0;
      mem_data_in <= '0;
      busy        <= 1'b0;
    end else begin
      // Pulsed outputs default low every cycle; mem_r_add is held explicitly.
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      rvalid0     <= 1'b0;
      rvalid1     <= 1'b0;
      mem_we      <= 1'b0;
      mem_re      <= 1'b0;
      mem_w_add   <= '0;
      mem_data_in <= '0;

      case (state)
        IDLE: begin
          if (any_req) begin
            win    <= pick;
            lat_wr <= sel_wr;
            prio   <= ~pick;
            gnt0   <= ~pick;
            gnt1   <= pick;
            busy   <= 1'b1;
            state  <= ISSUE;
            if (sel_wr) begin
              mem_we      <= 1'b1;
              mem_w_add   <= sel_addr;
              mem_data_in <= sel_wdata;
            end else begin
              mem_re    <= 1'b1;
              mem_r_add <= sel_addr;
            end
          end
        end

        ISSUE: begin
          // The memory samples the strobe on this edge.
          wait_cnt <= 2'd0;
          if (lat_wr) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            state <= RD_WAIT;
          end
        end

        RD_WAIT: begin
          // Read address stays on the bus until the data has been captured.
          if (wait_cnt == LAST_CNT) begin
            wait_cnt  <= 2'd0;
            mem_r_add <= '0;
            state     <= RD_DONE;
            if (win) begin
              rdata1  <= mem_data_out;
              rvalid1 <= 1'b1;
            end else begin
              rdata0  <= mem_data_out;
              rvalid0 <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end

        RD_DONE: begin
          // No request sampling here; arbitration resumes from IDLE.
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Self-checking bench for mem_rr_arbiter: a behavioural memory, a
// transaction-level expectation timeline checked every cycle, directed
// scenarios with literal expectations, then randomized traffic and resets.
module tb_mem_rr_arbiter #(parameter int RD_LAT = 1);

  localparam int NC = 8192;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req0 = 1'b0, wr0 = 1'b0, req1 = 1'b0, wr1 = 1'b0;
  logic [3:0] addr0 = 4'd0, addr1 = 4'd0;
  logic [7:0] wdata0 = 8'd0, wdata1 = 8'd0;
  logic       gnt0, gnt1, rvalid0, rvalid1, mem_we, mem_re, busy;
  logic [7:0] rdata0, rdata1, mem_data_in, mem_data_out;
  logic [3:0] mem_w_add, mem_r_add;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_rr_arbiter #(.ADDR_W(4), .DATA_W(8), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .mem_we(mem_we), .mem_re(mem_re), .mem_w_add(mem_w_add),
    .mem_r_add(mem_r_add), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .busy(busy)
  );

  // Behavioural memory: contents survive reset; read data is valid only in
  // the cycle RD_LAT edges after re is sampled, junk otherwise.
  logic [7:0] mem    [16]     = '{default: 8'h00};
  logic [7:0] pipe_d [RD_LAT] = '{default: 8'h00};
  logic       pipe_v [RD_LAT] = '{default: 1'b0};
  logic [7:0] junk = 8'h00;

  always @(posedge clk) begin
    if (mem_we) mem[mem_w_add] <= mem_data_in;
    pipe_v[0] <= mem_re;
    pipe_d[0] <= mem[mem_r_add];
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_v[i] <= pipe_v[i-1];
      pipe_d[i] <= pipe_d[i-1];
    end
    junk <= 8'($urandom);
  end
  assign mem_data_out = pipe_v[RD_LAT-1] ? pipe_d[RD_LAT-1] : junk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Expected-output timeline, indexed by cycle number.
  bit         e_gnt0 [NC], e_gnt1 [NC], e_we [NC], e_re [NC];
  bit         e_rv0  [NC], e_rv1  [NC], e_busy [NC];
  logic [3:0] e_wadd [NC], e_radd [NC];
  logic [7:0] e_din  [NC], e_rd   [NC];

  // Model + compare process. At each falling edge: apply reset, check the
  // current cycle, then arbitrate on the inputs the next rising edge samples
  // and lay out the whole transaction on the timeline.
  initial begin
    logic [7:0] m_mem [16];
    bit         m_prio, w, is_wr;
    int         free_neg, c, t;
    logic [3:0] a;
    logic [7:0] d, cur_rd0, cur_rd1;
    for (int i = 0; i < NC; i++) begin
      e_gnt0[i] = 0; e_gnt1[i] = 0; e_we[i] = 0; e_re[i] = 0;
      e_rv0[i] = 0; e_rv1[i] = 0; e_busy[i] = 0;
      e_wadd[i] = 0; e_radd[i] = 0; e_din[i] = 0; e_rd[i] = 0;
    end
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    m_prio = 0; free_neg = 0; cur_rd0 = 0; cur_rd1 = 0;
    forever begin
      @(negedge clk);
      c = cyc;
      if (!rst) begin
        for (int i = c; i < c + RD_LAT + 4 && i < NC; i++) begin
          e_gnt0[i] = 0; e_gnt1[i] = 0; e_we[i] = 0; e_re[i] = 0;
          e_rv0[i] = 0; e_rv1[i] = 0; e_busy[i] = 0;
          e_wadd[i] = 0; e_radd[i] = 0; e_din[i] = 0;
        end
        m_prio = 0; free_neg = 0; cur_rd0 = 0; cur_rd1 = 0;
      end
      if (c < NC) begin
        if (e_rv0[c]) cur_rd0 = e_rd[c];
        if (e_rv1[c]) cur_rd1 = e_rd[c];
        if (e_we[c]) m_mem[e_wadd[c]] = e_din[c];
        chk("gnt0",        int'(gnt0),        int'(e_gnt0[c]));
        chk("gnt1",        int'(gnt1),        int'(e_gnt1[c]));
        chk("mem_we",      int'(mem_we),      int'(e_we[c]));
        chk("mem_re",      int'(mem_re),      int'(e_re[c]));
        chk("mem_w_add",   int'(mem_w_add),   int'(e_wadd[c]));
        chk("mem_data_in", int'(mem_data_in), int'(e_din[c]));
        chk("mem_r_add",   int'(mem_r_add),   int'(e_radd[c]));
        chk("rvalid0",     int'(rvalid0),     int'(e_rv0[c]));
        chk("rvalid1",     int'(rvalid1),     int'(e_rv1[c]));
        chk("rdata0",      int'(rdata0),      int'(cur_rd0));
        chk("rdata1",      int'(rdata1),      int'(cur_rd1));
        chk("busy",        int'(busy),        int'(e_busy[c]));
      end
      if (rst && c >= free_neg && (req0 || req1) && c + RD_LAT + 4 < NC) begin
        w      = (req0 && req1) ? m_prio : req1;
        m_prio = !w;
        is_wr  = w ? wr1 : wr0;
        a      = w ? addr1 : addr0;
        d      = w ? wdata1 : wdata0;
        t      = c + 1;
        if (w) e_gnt1[t] = 1; else e_gnt0[t] = 1;
        if (is_wr) begin
          e_we[t] = 1; e_wadd[t] = a; e_din[t] = d; e_busy[t] = 1;
          free_neg = c + 2;
        end else begin
          e_re[t] = 1;
          for (int k = 0; k <= RD_LAT; k++) e_radd[t+k] = a;
          for (int k = 0; k <= RD_LAT + 1; k++) e_busy[t+k] = 1;
          if (w) e_rv1[t+RD_LAT+1] = 1; else e_rv0[t+RD_LAT+1] = 1;
          e_rd[t+RD_LAT+1] = m_mem[a];
          free_neg = c + RD_LAT + 3;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int r, input bit w, input int a, input int d);
    if (r == 0) begin req0 = 1; wr0 = w; addr0 = 4'(a); wdata0 = 8'(d); end
    else        begin req1 = 1; wr1 = w; addr1 = 4'(a); wdata1 = 8'(d); end
  endtask

  // Wait (bounded) for the requester's grant and drop its request in that cycle.
  task automatic wait_gnt(input int r, output int gc);
    gc = -1;
    for (int k = 0; k < 40 && gc < 0; k++) begin
      tick();
      if ((r == 0 && gnt0) || (r == 1 && gnt1)) gc = cyc;
    end
    if (r == 0) req0 = 0; else req1 = 0;
    chk(r == 0 ? "gnt0_seen" : "gnt1_seen", int'(gc >= 0), 1);
  endtask

  task automatic wait_rv(input int r, output int rc, output int rd);
    rc = -1; rd = 0;
    for (int k = 0; k < 20 && rc < 0; k++) begin
      tick();
      if (r == 0 && rvalid0) begin rc = cyc; rd = int'(rdata0); end
      if (r == 1 && rvalid1) begin rc = cyc; rd = int'(rdata1); end
    end
    chk("rvalid_seen", int'(rc >= 0), 1);
  endtask

  task automatic do_reset(input int n);
    rst = 0;
    #1;
    chk("rst_busy",    int'(busy), 0);
    chk("rst_strobes", int'(mem_we | mem_re | gnt0 | gnt1 | rvalid0 | rvalid1), 0);
    chk("rst_r_add",   int'(mem_r_add), 0);
    chk("rst_rdata0",  int'(rdata0), 0);
    repeat (n) tick();
    rst = 1;
  endtask

  task automatic rand_fields(input int r, input bit q);
    if (r == 0) begin
      req0 = q; wr0 = 1'($urandom_range(0, 1)); addr0 = 4'($urandom); wdata0 = 8'($urandom);
    end else begin
      req1 = q; wr1 = 1'($urandom_range(0, 1)); addr1 = 4'($urandom); wdata1 = 8'($urandom);
    end
  endtask

  task automatic rand_requester(input int r, input int n);
    bit rq, g;
    for (int k = 0; k < n; k++) begin
      tick();
      rq = (r == 0) ? req0 : req1;
      g  = (r == 0) ? gnt0 : gnt1;
      if (rq && g) rand_fields(r, $urandom_range(0, 1) == 1);
      else if (!rq && $urandom_range(0, 3) == 0) rand_fields(r, 1'b1);
    end
  endtask

  task automatic rand_reset(input int n);
    int hold;
    hold = 0;
    for (int k = 0; k < n; k++) begin
      tick();
      if (!rst) begin
        if (hold == 0) rst = 1; else hold--;
      end else if ($urandom_range(0, 199) == 0) begin
        rst = 0;
        hold = $urandom_range(0, 2);
      end
    end
    rst = 1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int gc, gc1, rc, rd, n0, nseq, g0cnt, g1cnt, raise_c;
    int wseq[4], cseq[4];
    rst = 0;
    repeat (4) tick();
    rst = 1;
    tick();

    // Single write then read-back of address 4.
    issue(0, 1, 4, 5);
    wait_gnt(0, gc);
    chk("t2_we",   int'(mem_we), 1);
    chk("t2_wadd", int'(mem_w_add), 4);
    chk("t2_din",  int'(mem_data_in), 5);
    issue(0, 0, 4, 0);
    wait_gnt(0, gc);
    chk("t2_re",   int'(mem_re), 1);
    chk("t2_radd", int'(mem_r_add), 4);
    wait_rv(0, rc, rd);
    chk("t2_rd_latency", rc - gc, RD_LAT + 1);
    chk("t2_rdata", rd, 5);

    // Contention from reset: both held for two writes each.
    do_reset(2);
    issue(0, 1, 0, 10);
    issue(1, 1, 1, 8);
    nseq = 0; g0cnt = 0; g1cnt = 0;
    for (int k = 0; k < 30 && nseq < 4; k++) begin
      tick();
      if (gnt0 || gnt1) begin
        wseq[nseq] = gnt1 ? 1 : 0;
        cseq[nseq] = cyc;
        nseq++;
        if (gnt0) begin g0cnt++; if (g0cnt == 2) req0 = 0; end
        if (gnt1) begin g1cnt++; if (g1cnt == 2) req1 = 0; end
      end
    end
    req0 = 0; req1 = 0;
    chk("t3_grants", nseq, 4);
    if (nseq == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("t3_winner", wseq[i], i % 2);
        chk("t3_spacing", cseq[i] - cseq[0], 2 * i);
      end
    end
    issue(0, 0, 0, 0);
    wait_gnt(0, gc);
    wait_rv(0, rc, rd);
    chk("t3_read_addr0", rd, 10);
    issue(0, 0, 1, 0);
    wait_gnt(0, gc);
    wait_rv(0, rc, rd);
    chk("t3_read_addr1", rd, 8);

    // Fairness: req0 held with repeated writes, req1 raised once.
    issue(0, 1, 3, 7);
    repeat (3) tick();
    issue(1, 1, 5, 9);
    raise_c = cyc;
    n0 = 0; gc1 = -1;
    for (int k = 0; k < 20 && gc1 < 0; k++) begin
      tick();
      if (gnt1) begin gc1 = cyc; req1 = 0; end
      else if (gnt0) n0++;
    end
    req0 = 0;
    chk("t4_gnt1_seen", int'(gc1 >= 0), 1);
    chk("t4_gnt0_between", n0, 0);
    chk("t4_wait_bound", int'(gc1 - raise_c <= 2), 1);

    // Read in flight while the other requester raises a write.
    tick();
    issue(0, 0, 1, 0);
    wait_gnt(0, gc);
    tick();
    issue(1, 1, 2, 33);
    wait_rv(0, rc, rd);
    chk("t5_rdata0", rd, 8);
    wait_gnt(1, gc1);
    chk("t5_gnt1_after_rvalid", gc1 - rc, 2);
    chk("t5_rdata1_unchanged", int'(rdata1), 0);

    // Reset during RD_WAIT aborts the read; memory keeps its contents.
    tick();
    issue(0, 0, 0, 0);
    wait_gnt(0, gc);
    tick();
    do_reset(1);
    n0 = 0;
    repeat (RD_LAT + 3) begin
      tick();
      if (rvalid0) n0++;
    end
    chk("t6_no_rvalid", n0, 0);
    issue(0, 0, 0, 0);
    wait_gnt(0, gc);
    wait_rv(0, rc, rd);
    chk("t6_read_addr0", rd, 10);
    chk("t6_rd_latency", rc - gc, RD_LAT + 1);

    // Randomized traffic with occasional resets.
    fork
      rand_requester(0, 2500);
      rand_requester(1, 2500);
      rand_reset(2500);
    join
    req0 = 0; req1 = 0; rst = 1;
    repeat (10) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_rr_arbiter.md
Name: mem_rr_arbiter

Overview:
Round-robin arbiter and sequencer that shares the single-port-per-direction 16x8 memory between two requesters.
- Each requester issues single read or write transactions over a req/gnt handshake.
- The block drives the memory's we/re/w_add/r_add/data_in and returns read data with a per-requester valid pulse.
- Sits between the memory and two client blocks; one memory access is in flight at a time.

Parameters:
ADDR_W, 4, memory address width (16 locations)
DATA_W, 8, memory data width
RD_LAT, 1, memory read latency in cycles from re-sampling edge to data_out valid; legal 1..3

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset, asynchronous, active-low
req0  in  1  requester 0 transaction request
wr0  in  1  requester 0 direction: 1 write, 0 read
addr0  in  ADDR_W  requester 0 address
wdata0  in  DATA_W  requester 0 write data
gnt0  out  1  requester 0 grant, one-cycle pulse
rvalid0  out  1  requester 0 read data valid, one-cycle pulse
rdata0  out  DATA_W  requester 0 read data
req1, wr1, addr1, wdata1, gnt1, rvalid1, rdata1: same as requester 0, for requester 1
mem_we  out  1  to memory we
mem_re  out  1  to memory re
mem_w_add  out  ADDR_W  to memory w_add
mem_r_add  out  ADDR_W  to memory r_add
mem_data_in  out  DATA_W  to memory data_in
mem_data_out  in  DATA_W  from memory data_out
busy  out  1  high whenever state != IDLE

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. Clock port clk, reset port rst (rst=0 resets).
- Reset values:
  - All outputs 0.
  - State IDLE; priority pointer prio=0; RD_WAIT counter 0.
- FSM states: IDLE, ISSUE, RD_WAIT, RD_DONE.
- IDLE:
  - On the edge where any req is 1, select the winner and latch its wr/addr/wdata. Go to ISSUE.
  - If no req, stay in IDLE.
- Arbitration:
  - Only one req high: that requester wins.
  - Both high: requester prio wins.
  - After every grant, prio is set to the non-winner.
- ISSUE (exactly 1 cycle):
  - gnt of the winner = 1.
  - Write: mem_we=1, mem_w_add=latched addr, mem_data_in=latched wdata. Next state IDLE.
  - Read: mem_re=1, mem_r_add=latched addr. Next state RD_WAIT.
  - All mem_* outputs are registered; 0 outside ISSUE, except mem_r_add, which holds its value through RD_WAIT.
- RD_WAIT:
  - Stays RD_LAT cycles (counter).
  - On the last edge, captures mem_data_out into the winner's rdata. Go to RD_DONE.
- RD_DONE (1 cycle):
  - Winner's rvalid=1.
  - rdata holds its value until that requester's next read completes.
  - Next state IDLE. Arbitration resumes from IDLE, so there is no request sampling in RD_DONE.
- Latency and throughput:
  - Write: req sampled at edge E → gnt/mem_we in cycle E+1 → free at E+2. Back-to-back writes every 2 cycles.
  - Read: gnt/mem_re in cycle T; rvalid in cycle T+RD_LAT+1. Read occupancy is RD_LAT+3 cycles including IDLE.
- Requester rules:
  - Hold req/wr/addr/wdata stable until gnt.
  - Drop req in the gnt cycle. A req still high on the edge after gnt (when the block is in IDLE) is a new transaction.
  - Requests raised while busy wait; they are not lost.
- Simultaneous events: a request arriving in the same cycle as another requester's rvalid is arbitrated normally on the next IDLE edge.
- Wrap-around: addresses pass through unmodified; ADDR_W bits only.
- Reset mid-operation:
  - In-flight transaction is aborted and no gnt/rvalid is produced.
  - mem_we/mem_re drop immediately (asynchronously).
  - prio returns to 0.

Test Plan:
1. Reset: rst=0 mid-run → all outputs 0, busy=0, prio=0 at once. Release rst → idle, no memory strobes.
2. Single write then read: req0 write addr=4 data=8'd5; then req0 read addr=4.
   - gnt0 pulse with mem_we=1, mem_w_add=4, mem_data_in=5.
   - Later gnt0 with mem_re=1, mem_r_add=4.
   - rvalid0=1, rdata0=5 exactly RD_LAT+1 cycles after the read gnt0.
3. Contention: req0 and req1 both write from reset (addr 0 = 10, addr 1 = 8), held high.
   - gnt0 first (prio=0), then gnt1, alternating every 2 cycles.
   - Readback gives 10 and 8.
4. Fairness: req0 held continuously with repeated writes, req1 raised once → req1 granted on the next arbitration after the current req0 transaction; never starved.
5. Read/request overlap: req0 read addr=1 in flight, req1 write raised during RD_WAIT.
   - No mem_we before rvalid0.
   - gnt1 issues in the cycle after the RD_DONE→IDLE transition.
   - rdata0=8, rdata1 unchanged.
6. Reset during RD_WAIT → no rvalid0. After release, a fresh read of addr 0 returns 10 (memory contents unaffected).
7. RD_LAT=3 build: repeat scenario 2 → rvalid0 four cycles after the read gnt0.
